// File: rtl/seq_dense_layer.sv
// Sequential fully-connected layer: one multiply-accumulate per cycle against external
// weight/bias ROMs, saturated to ACC_W, optional ReLU, and a running argmax.
module seq_dense_layer #(
    parameter  int IN_SIZE  = 4,
    parameter  int OUT_SIZE = 3,
    parameter  int DATA_W   = 16,
    parameter  int WEIGHT_W = 16,
    parameter  int ACC_W    = 40,
    parameter  int RELU_EN  = 1,
    localparam int WA_W     = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
    localparam int JW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_SIZE-1:0][DATA_W-1:0]     in_vec,
    output logic [WA_W-1:0]                    w_addr,
    input  logic signed [WEIGHT_W-1:0]         w_data,
    output logic [JW-1:0]                      b_addr,
    input  logic signed [WEIGHT_W-1:0]         b_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_SIZE-1:0][ACC_W-1:0]     out_vec,
    output logic [JW-1:0]                      out_argmax
);

    localparam int IW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int SUM_W = DATA_W + WEIGHT_W + $clog2(IN_SIZE) + 2;
    localparam int EXT_W = (SUM_W > ACC_W) ? SUM_W : ACC_W;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FIN,
        DONE
    } state_t;

    state_t                              state_q;
    logic [IW-1:0]                       i_q;
    logic [JW-1:0]                       j_q;
    logic [IN_SIZE-1:0][DATA_W-1:0]      x_q;
    logic signed [SUM_W-1:0]             acc_q;
    logic signed [ACC_W-1:0]             max_q;
    logic [OUT_SIZE-1:0][ACC_W-1:0]      out_vec_q;
    logic [JW-1:0]                       argmax_q;

    logic [IW-1:0]                       x_idx;
    logic signed [DATA_W-1:0]            x_sel;
    logic signed [PROD_W-1:0]            prod;
    logic signed [SUM_W-1:0]             acc_d;
    logic signed [SUM_W-1:0]             sum_fin;
    logic signed [EXT_W-1:0]             sum_ext;
    logic signed [ACC_W-1:0]             res_sat;
    logic signed [ACC_W-1:0]             res_d;
    logic                                new_max;

    // w_data lags w_addr by one cycle, so a MAC cycle consumes the element addressed in the
    // previous cycle (x[i-1]) and FIN consumes the last one.
    always_comb begin
        x_idx = i_q;
        if (state_q == MAC && i_q != '0) begin
            x_idx = i_q - 1'b1;
        end
        x_sel   = $signed(x_q[x_idx]);
        prod    = x_sel * w_data;
        acc_d   = (i_q == '0) ? '0 : acc_q + SUM_W'(prod);
        sum_fin = acc_q + SUM_W'(prod) + SUM_W'(b_data);
        sum_ext = EXT_W'(sum_fin);

        if (sum_ext > SAT_MAX) begin
            res_sat = SAT_MAX[ACC_W-1:0];
        end else if (sum_ext < SAT_MIN) begin
            res_sat = SAT_MIN[ACC_W-1:0];
        end else begin
            res_sat = sum_ext[ACC_W-1:0];
        end

        res_d = res_sat;
        if (RELU_EN != 0 && res_sat < 0) begin
            res_d = '0;
        end

        new_max = (j_q == '0) || (res_d > max_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            x_q       <= '0;
            acc_q     <= '0;
            max_q     <= '0;
            out_vec_q <= '0;
            argmax_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_vec;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (i_q == IW'(IN_SIZE - 1)) begin
                        state_q <= FIN;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                FIN: begin
                    out_vec_q[j_q] <= res_d;
                    if (new_max) begin
                        max_q    <= res_d;
                        argmax_q <= j_q;
                    end
                    if (j_q == JW'(OUT_SIZE - 1)) begin
                        state_q <= DONE;
                    end else begin
                        j_q     <= j_q + 1'b1;
                        i_q     <= '0;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_vec    = out_vec_q;
        out_argmax = argmax_q;
        w_addr     = '0;
        b_addr     = '0;
        if (state_q == MAC) begin
            w_addr = WA_W'(int'(j_q) * IN_SIZE + int'(i_q));
            b_addr = j_q;
        end
    end

endmodule

// File: tb/tb_seq_dense_layer.sv
// Scoreboarded bench: three 2x2 layers (ReLU, pass-through, 8-bit saturating) driven in
// lockstep with random vectors and checked against a plain-arithmetic reference.
module tb_seq_dense_layer;

    typedef struct {
        longint v0;
        longint v1;
        longint am;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [1:0][15:0]  in_vec;

    always #5 clk = ~clk;

    logic               in_ready_a, in_ready_b, in_ready_c;
    logic [1:0]         wa_a, wa_b, wa_c;
    logic [0:0]         ba_a, ba_b, ba_c;
    logic signed [15:0] wd_a, wd_b, wd_c, bd_a, bd_b, bd_c;
    logic               ov_a, ov_b, ov_c;
    logic [1:0][39:0]   vec_a, vec_b;
    logic [1:0][7:0]    vec_c;
    logic [0:0]         am_a, am_b, am_c;

    seq_dense_layer #(.IN_SIZE(2), .OUT_SIZE(2), .DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_vec(in_vec),
        .w_addr(wa_a), .w_data(wd_a), .b_addr(ba_a), .b_data(bd_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_vec(vec_a), .out_argmax(am_a)
    );

    seq_dense_layer #(.IN_SIZE(2), .OUT_SIZE(2), .DATA_W(16), .WEIGHT_W(16), .ACC_W(40), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_vec(in_vec),
        .w_addr(wa_b), .w_data(wd_b), .b_addr(ba_b), .b_data(bd_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_vec(vec_b), .out_argmax(am_b)
    );

    seq_dense_layer #(.IN_SIZE(2), .OUT_SIZE(2), .DATA_W(16), .WEIGHT_W(16), .ACC_W(8), .RELU_EN(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_vec(in_vec),
        .w_addr(wa_c), .w_data(wd_c), .b_addr(ba_c), .b_data(bd_c),
        .out_valid(ov_c), .out_ready(out_ready), .out_vec(vec_c), .out_argmax(am_c)
    );

    // ROM contents: set 0 is w={1,2,3,-4}, b={10,-5}; set 1 is all-ones weights, zero bias.
    function automatic longint romw(input int set, input int a);
        if (set == 1) return 1;
        case (a)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return -4;
        endcase
    endfunction

    function automatic longint romb(input int set, input int a);
        if (set == 1) return 0;
        return (a == 0) ? 10 : -5;
    endfunction

    always @(posedge clk) begin
        wd_a <= 16'(romw(0, int'(wa_a)));
        bd_a <= 16'(romb(0, int'(ba_a)));
        wd_b <= 16'(romw(0, int'(wa_b)));
        bd_b <= 16'(romb(0, int'(ba_b)));
        wd_c <= 16'(romw(1, int'(wa_c)));
        bd_c <= 16'(romb(1, int'(ba_c)));
    end

    function automatic exp_t model(input int set, input int accw, input bit relu,
                                   input longint x0, input longint x1);
        exp_t   e;
        longint s;
        longint hi;
        longint lo;
        longint v[2];
        hi = (longint'(1) <<< (accw - 1)) - 1;
        lo = -hi - 1;
        for (int j = 0; j < 2; j++) begin
            s = romb(set, j) + x0 * romw(set, 2 * j) + x1 * romw(set, 2 * j + 1);
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            if (relu && s < 0) s = 0;
            v[j] = s;
        end
        e.v0 = v[0];
        e.v1 = v[1];
        e.am = (v[1] > v[0]) ? 1 : 0;
        return e;
    endfunction

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   b2b_mode = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_out(input string n, input exp_t e, input longint v0, input longint v1,
                             input longint am);
        chk({n, "_out0"}, v0, e.v0);
        chk({n, "_out1"}, v1, e.v1);
        chk({n, "_argmax"}, am, e.am);
    endtask

    task automatic unexpected(input string n);
        checks++;
        failures++;
        $display("FAIL %s actual=result_presented required=none_outstanding", n);
    endtask

    always @(negedge clk) begin
        if (!rst && ov_a && out_ready) begin
            if (q_a.size() == 0) unexpected("extra_out_a");
            else check_out("a", q_a.pop_front(), $signed(vec_a[0]), $signed(vec_a[1]), longint'(am_a));
        end
    end

    always @(negedge clk) begin
        if (!rst && ov_b && out_ready) begin
            if (q_b.size() == 0) unexpected("extra_out_b");
            else check_out("b", q_b.pop_front(), $signed(vec_b[0]), $signed(vec_b[1]), longint'(am_b));
        end
    end

    always @(negedge clk) begin
        if (!rst && ov_c && out_ready) begin
            if (q_c.size() == 0) unexpected("extra_out_c");
            else check_out("c", q_c.pop_front(), $signed(vec_c[0]), $signed(vec_c[1]), longint'(am_c));
        end
    end

    logic prev_valid = 1'b0;
    int   last_rise = -1;

    always @(negedge clk) begin
        if (!rst && ov_a && !prev_valid) begin
            chk("latency", longint'(cyc - acc_cyc), 6);
            if (b2b_mode && last_rise >= 0) chk("b2b_period", longint'(cyc - last_rise), 8);
            last_rise <= cyc;
        end else if (!b2b_mode) begin
            last_rise <= -1;
        end
        prev_valid <= ov_a && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input bit hold);
        int n;
        n = 0;
        in_vec[0] = a;
        in_vec[1] = b;
        in_valid  = 1'b1;
        while (!in_ready_a && n < 60) begin
            tick();
            n++;
        end
        chk("accept_ready", longint'(in_ready_a), 1);
        if (!in_ready_a) begin
            in_valid = 1'b0;
            return;
        end
        q_a.push_back(model(0, 40, 1'b1, longint'(a), longint'(b)));
        q_b.push_back(model(0, 40, 1'b0, longint'(a), longint'(b)));
        q_c.push_back(model(1, 8, 1'b1, longint'(a), longint'(b)));
        acc_cyc = cyc + 1;
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_drain_a"}, longint'(q_a.size()), 0);
        chk({tag, "_drain_b"}, longint'(q_b.size()), 0);
        chk({tag, "_drain_c"}, longint'(q_c.size()), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready_a"}, longint'(in_ready_a), 1);
        chk({tag, "_in_ready_b"}, longint'(in_ready_b), 1);
        chk({tag, "_in_ready_c"}, longint'(in_ready_c), 1);
        chk({tag, "_out_valid"}, longint'(ov_a | ov_b | ov_c), 0);
        chk({tag, "_vec_a_zero"}, longint'(vec_a == '0), 1);
        chk({tag, "_vec_b_zero"}, longint'(vec_b == '0), 1);
        chk({tag, "_vec_c_zero"}, longint'(vec_c == '0), 1);
        chk({tag, "_argmax"}, longint'(am_a | am_b | am_c), 0);
        chk({tag, "_w_addr"}, longint'(wa_a), 0);
        chk({tag, "_b_addr"}, longint'(ba_a), 0);
    endtask

    function automatic logic signed [15:0] rnd();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return 16'(int'($urandom_range(0, 60)) - 30);
    endfunction

    initial begin
        int               n;
        logic [1:0][39:0] snap;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst       = 1'b0;
        out_ready = 1'b1;

        send(16'sd3, 16'sd5, 1'b0);
        send(16'sd100, 16'sd100, 1'b0);
        send(16'sd0, -16'sd10, 1'b0);
        send(-16'sd3, -16'sd5, 1'b0);
        send(16'sd32767, 16'sd32767, 1'b0);
        send(-16'sd32768, 16'sd32767, 1'b0);
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(rnd(), rnd(), 1'b0);
        end
        wait_drain("random");

        out_ready = 1'b0;
        send(16'sd3, 16'sd5, 1'b0);
        n = 0;
        while (!ov_a && n < 40) begin
            tick();
            n++;
        end
        chk("bp_valid_rise", longint'(ov_a), 1);
        chk("bp_out0", $signed(vec_a[0]), 23);
        snap = vec_a;
        repeat (5) begin
            tick();
            chk("bp_out_valid", longint'(ov_a), 1);
            chk("bp_in_ready", longint'(in_ready_a), 0);
            chk("bp_vec_stable", longint'(vec_a == snap), 1);
            chk("bp_w_addr", longint'(wa_a), 0);
            chk("bp_b_addr", longint'(ba_a), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", longint'(in_ready_a), 1);
        chk("bp_release_out_valid", longint'(ov_a), 0);
        chk("bp_idle_holds_vec", longint'(vec_a == snap), 1);
        wait_drain("bp");

        send(16'sd3, 16'sd5, 1'b0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_idle_zero("midrst");
        q_a.delete();
        q_b.delete();
        q_c.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(16'sd3, 16'sd5, 1'b0);
        wait_drain("post_reset");

        b2b_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(rnd(), rnd(), k != 7);
        end
        wait_drain("b2b");
        b2b_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
